// File: rtl/gate_share_arbiter_pkg.sv
// Shared types for the gate_share_arbiter slice: FSM state encoding and op counter width.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gate_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int OPCNT_W = 8;

endpackage

// File: rtl/gate_share_arbiter_and_unit.sv
// Shared DW-wide AND datapath fed from the arbiter's captured operand registers.
// Latency: combinational, zero cycles.
// Backpressure: none; the arbiter registers the result.
module and_unit #(
    parameter int DW = 1
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] y_o
);

    assign y_o = a_i & b_i;

endmodule

// File: rtl/gate_share_arbiter.sv
// Round-robin arbiter sharing one AND unit among N_REQ requesters; optional op_cnt via GATE_ARB_OPCNT_EN.
// Latency: grant 1 cycle after req sampled in IDLE, done/and_o 2 cycles after, 3 cycles per operation.
// Backpressure: requests raised while busy wait in req and are re-arbitrated on return to IDLE.
module gate_share_arbiter
    import gate_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   a,
    input  logic [N_REQ*DW-1:0]   b,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic [DW-1:0]         and_o,
    output logic                  busy
`ifdef GATE_ARB_OPCNT_EN
    ,
    output logic [OPCNT_W-1:0]    op_cnt
`endif
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] GNT_ONE = N_REQ'(1);

    state_t             state_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   done_q;
    logic [DW-1:0]      and_q;
    logic [PW-1:0]      ptr_q;
    logic [DW-1:0]      opa_q;
    logic [DW-1:0]      opb_q;
    logic [DW-1:0]      and_w;
    logic [PW-1:0]      win_d;
`ifdef GATE_ARB_OPCNT_EN
    logic [OPCNT_W-1:0] op_cnt_q;
`endif

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return PW'(s);
    endfunction

    // Scan farthest-to-nearest from ptr so the nearest asserted requester wins last.
    function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [PW-1:0] p);
        logic [PW-1:0] idx;
        logic [PW-1:0] w;
        w = p;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = wrap_add(p, k);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    always_comb begin
        win_d = rr_pick(req, ptr_q);
    end

    and_unit #(.DW(DW)) u_and (
        .a_i (opa_q),
        .b_i (opb_q),
        .y_o (and_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            and_q    <= '0;
            ptr_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
`ifdef GATE_ARB_OPCNT_EN
            op_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_EXEC;
                        gnt_q   <= GNT_ONE << win_d;
                        opa_q   <= a[win_d*DW +: DW];
                        opb_q   <= b[win_d*DW +: DW];
                        ptr_q   <= wrap_add(win_d, 1);
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_DONE;
                    and_q   <= and_w;
                    done_q  <= gnt_q;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= '0;
                    gnt_q   <= '0;
`ifdef GATE_ARB_OPCNT_EN
                    if (op_cnt_q != '1) op_cnt_q <= op_cnt_q + 1'b1;
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= '0;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign and_o = and_q;
    assign busy  = (state_q != ST_IDLE);
`ifdef GATE_ARB_OPCNT_EN
    assign op_cnt = op_cnt_q;
`endif

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Directed and randomized-operand bench for gate_share_arbiter (N_REQ=4, DW=1).
// Checks reset, latency, round-robin order, operand capture, mid-op reset and op_cnt when enabled.
module tb_gate_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] gnt;
    logic [3:0] done;
    logic [0:0] and_o;
    logic       busy;
`ifdef GATE_ARB_OPCNT_EN
    logic [7:0] op_cnt;
`endif

    int n_chk;
    int n_bad;
    int m_ptr;

    gate_share_arbiter #(.N_REQ(4), .DW(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .a     (a),
        .b     (b),
        .gnt   (gnt),
        .done  (done),
        .and_o (and_o),
        .busy  (busy)
`ifdef GATE_ARB_OPCNT_EN
        ,
        .op_cnt(op_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    initial begin
        int         w;
        logic       exp_and;
        logic [3:0] exp_gnt;

        n_chk = 0;
        n_bad = 0;
        m_ptr = 0;
        rst_n = 1'b0;
        req   = '0;
        a     = '0;
        b     = '0;
        #3;
        chk("rst_gnt",  32'(gnt),   32'h0);
        chk("rst_done", 32'(done),  32'h0);
        chk("rst_and",  32'(and_o), 32'h0);
        chk("rst_busy", 32'(busy),  32'h0);
        tick();
        rst_n = 1'b1;

        // single request from requester 1
        req = 4'b0010; a = 4'b0010; b = 4'b0010;
        tick();
        chk("single_gnt",  32'(gnt),  32'h2);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_nodone", 32'(done), 32'h0);
        req = '0;
        tick();
        chk("single_done", 32'(done),  32'h2);
        chk("single_and",  32'(and_o), 32'h1);
        tick();
        chk("single_idle_busy", 32'(busy), 32'h0);
        chk("single_idle_done", 32'(done), 32'h0);
        chk("single_idle_gnt",  32'(gnt),  32'h0);

        // full contention from ptr=0
        do_reset();
        req = 4'b1111; a = '0; b = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
            if (i == 4) req = '0;
            tick();
            chk("rr_done", 32'(done), 32'(4'b0001 << (i % 4)));
            if (i < 4) tick();
        end
        tick();
        chk("rr_and", 32'(and_o), 32'h0);

        // operands captured at grant (ptr=1, wraps to requester 0)
        req = 4'b0001; a = 4'b0001; b = 4'b0001;
        tick();
        chk("cap_gnt", 32'(gnt), 32'h1);
        b = '0; a = '0; req = '0;
        tick();
        chk("cap_done", 32'(done),  32'h1);
        chk("cap_and",  32'(and_o), 32'h1);
        tick();

        // reset mid-operation, then lone request from requester 3
        req = 4'b0110;
        tick();
        chk("mid_gnt", 32'(gnt), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",  32'(gnt),   32'h0);
        chk("mid_rst_done", 32'(done),  32'h0);
        chk("mid_rst_and",  32'(and_o), 32'h0);
        chk("mid_rst_busy", 32'(busy),  32'h0);
        tick();
        chk("mid_rst_nodone", 32'(done), 32'h0);
        rst_n = 1'b1;
        req = 4'b1000;
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'h8);
        req = '0;
        tick();
        chk("post_rst_done", 32'(done), 32'h8);
        tick();

        // ptr advances to 2, reset must return it to 0
        req = 4'b0110;
        tick();
        chk("ptr_pre_gnt", 32'(gnt), 32'h2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1111;
        tick();
        chk("ptr_rst_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        tick();

        // random operands and request sets
        do_reset();
        for (int n = 0; n < 200; n++) begin
            req = 4'($urandom_range(1, 15));
            a   = 4'($urandom);
            b   = 4'($urandom);
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            exp_gnt = 4'b0001 << w;
            exp_and = a[w] & b[w];
            m_ptr = (w + 1) % 4;
            tick();
            chk("rnd_gnt", 32'(gnt), 32'(exp_gnt));
            req = 4'($urandom);
            a   = 4'($urandom);
            b   = 4'($urandom);
            tick();
            chk("rnd_done", 32'(done),  32'(exp_gnt));
            chk("rnd_and",  32'(and_o), 32'(exp_and));
            tick();
            chk("rnd_idle", 32'(done), 32'h0);
        end

`ifdef GATE_ARB_OPCNT_EN
        do_reset();
        req = '0;
        chk("cnt_rst", 32'(op_cnt), 32'h0);
        req = 4'b1111;
        for (int n = 0; n < 300; n++) begin
            tick(); tick(); tick();
            if (n == 9)  chk("cnt_10",  32'(op_cnt), 32'd10);
            if (n == 254) chk("cnt_255", 32'(op_cnt), 32'd255);
        end
        chk("cnt_sat", 32'(op_cnt), 32'd255);
        req = '0;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
